// File: rtl/sram_2p_bist_pkg.sv
// Shared types and March C- element tables for the 2P SRAM self-test.
// Element tables are indexed by march_e (bit n describes element Mn).
package sram_2p_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_e;

    typedef enum logic [2:0] {
        M0,
        M1,
        M2,
        M3,
        M4,
        M5
    } march_e;

    // 1 = element walks addresses downward
    localparam logic [5:0] T_DOWN = 6'b011000;
    // 1 = element performs a read
    localparam logic [5:0] T_RD   = 6'b111110;
    // background value the read must return
    localparam logic [5:0] T_EXP  = 6'b010100;
    // 1 = element performs a write
    localparam logic [5:0] T_WR   = 6'b011111;
    // background value written
    localparam logic [5:0] T_WBIT = 6'b001010;

    function automatic march_e next_elem(march_e e);
        return march_e'(e + 3'd1);
    endfunction

endpackage

// File: rtl/sram_2p_array.sv
// Two-port storage: per-bit masked write on A, registered read on B.
// Read-before-write on same-address collisions; contents are not reset.
module sram_2p_array #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [P_ADDR_WIDTH-1:0] waddr,
    input  logic [P_DATA_WIDTH-1:0] din,
    input  logic [P_DATA_WIDTH-1:0] bm,
    input  logic                    re,
    input  logic [P_ADDR_WIDTH-1:0] raddr,
    output logic [P_DATA_WIDTH-1:0] dout
);
    localparam int DEPTH = 2 ** P_ADDR_WIDTH;

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    // Masked write: only bits with bm=1 take the new data
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~bm) | (din & bm);
        end
    end

    // Registered read port; holds its value when not reading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/sram_2p_march_bist.sv
// 2P SRAM with integrated March C- self-test engine.
// Define SRAM_2P_BIST_FAIL_LOG_EN to add first-failure address/data ports.
module sram_2p_march_bist
    import sram_2p_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    A_MEN,
    input  logic                    A_WEN,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [P_DATA_WIDTH-1:0] A_DIN,
    input  logic [P_DATA_WIDTH-1:0] A_BM,
    input  logic                    B_MEN,
    input  logic                    B_REN,
    input  logic [P_ADDR_WIDTH-1:0] B_ADDR,
    output logic [P_DATA_WIDTH-1:0] B_DOUT,
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
    output logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
    output logic [P_DATA_WIDTH-1:0] BIST_FAIL_DATA,
`endif
    input  logic                    BIST_START,
    output logic                    BIST_BUSY,
    output logic                    BIST_DONE,
    output logic                    BIST_FAIL
);
    state_e                  state;
    march_e                  elem;
    march_e                  nxt;
    logic [P_ADDR_WIDTH-1:0] addr;
    logic                    last;
    logic                    cmp_valid;
    logic [P_DATA_WIDTH-1:0] cmp_exp;
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
    logic [P_ADDR_WIDTH-1:0] cmp_addr;
`endif

    logic                    bist_we;
    logic                    bist_re;
    logic                    arr_we;
    logic                    arr_re;
    logic [P_ADDR_WIDTH-1:0] arr_waddr;
    logic [P_ADDR_WIDTH-1:0] arr_raddr;
    logic [P_DATA_WIDTH-1:0] arr_din;
    logic [P_DATA_WIDTH-1:0] arr_bm;

    // Current march op and port mux; BUSY hands both ports to the engine
    always_comb begin
        nxt       = next_elem(elem);
        last      = T_DOWN[elem] ? (addr == '0) : (addr == '1);
        bist_we   = (state == RUN) && T_WR[elem];
        bist_re   = (state == RUN) && T_RD[elem];
        arr_we    = BIST_BUSY ? bist_we : (A_MEN && A_WEN);
        arr_waddr = BIST_BUSY ? addr : A_ADDR;
        arr_din   = BIST_BUSY ? {P_DATA_WIDTH{T_WBIT[elem]}} : A_DIN;
        arr_bm    = BIST_BUSY ? {P_DATA_WIDTH{1'b1}} : A_BM;
        arr_re    = BIST_BUSY ? bist_re : (B_MEN && B_REN);
        arr_raddr = BIST_BUSY ? addr : B_ADDR;
    end

    sram_2p_array #(
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_array (
        .clk  (CLK),
        .rst  (RST),
        .we   (arr_we),
        .waddr(arr_waddr),
        .din  (arr_din),
        .bm   (arr_bm),
        .re   (arr_re),
        .raddr(arr_raddr),
        .dout (B_DOUT)
    );

    // Engine FSM, address walk, compare pipeline and sticky status
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            elem      <= M0;
            addr      <= '0;
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            BIST_BUSY <= 1'b0;
            BIST_DONE <= 1'b0;
            BIST_FAIL <= 1'b0;
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
            cmp_addr       <= '0;
            BIST_FAIL_ADDR <= '0;
            BIST_FAIL_DATA <= '0;
`endif
        end else begin
            cmp_valid <= bist_re;
            cmp_exp   <= {P_DATA_WIDTH{T_EXP[elem]}};
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
            cmp_addr  <= addr;
`endif
            if (cmp_valid && (B_DOUT != cmp_exp)) begin
                BIST_FAIL <= 1'b1;
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
                if (!BIST_FAIL) begin
                    BIST_FAIL_ADDR <= cmp_addr;
                    BIST_FAIL_DATA <= B_DOUT;
                end
`endif
            end
            unique case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (BIST_START) begin
                        state     <= RUN;
                        elem      <= M0;
                        addr      <= '0;
                        BIST_BUSY <= 1'b1;
                        BIST_DONE <= 1'b0;
                        BIST_FAIL <= 1'b0;
`ifdef SRAM_2P_BIST_FAIL_LOG_EN
                        BIST_FAIL_ADDR <= '0;
                        BIST_FAIL_DATA <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!last) begin
                        addr <= T_DOWN[elem] ? addr - 1'b1 : addr + 1'b1;
                    end else if (elem == M5) begin
                        state <= DRAIN;
                    end else begin
                        elem <= nxt;
                        addr <= T_DOWN[nxt] ? {P_ADDR_WIDTH{1'b1}} : '0;
                    end
                end
                DRAIN: begin
                    state     <= FINISH;
                    addr      <= '0;
                    BIST_BUSY <= 1'b0;
                    BIST_DONE <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
